// File: rtl/gctr_pkg.sv
// gctr_pkg -- shared definitions for the 64-bit GCTR sequencing controller.
//
// Contents:
//   BLK_W / KEY_W  block and key widths of the PRESENT-80 datapath
//   LAT_CNT_W      width of the load-to-valid latency counter (latency 1..63)
//   ICB_DFLT       counter block used when a message starts with start_use_dflt=1
//   gctr_state_t   controller states
//   inc32()        GCTR counter increment (low 32 bits only, wraps, no carry up)
//   byte_mask()    final-block byte count -> 64-bit keep mask, MSB-first
package gctr_pkg;

   localparam int unsigned BLK_W     = 64;
   localparam int unsigned KEY_W     = 80;
   localparam int unsigned LAT_CNT_W = 6;

   localparam logic [BLK_W-1:0] ICB_DFLT = 64'hABAC8CA6000AA98A;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      XFER,
      OUT
   } gctr_state_t;

   // Only the low word counts; the upper word is the fixed IV part.
   function automatic logic [BLK_W-1:0] inc32(input logic [BLK_W-1:0] blk);
      return {blk[63:32], blk[31:0] + 32'd1};
   endfunction

   // nbytes=0 means a full block. Otherwise the top 8*nbytes bits are kept.
   function automatic logic [BLK_W-1:0] byte_mask(input logic [2:0] nbytes);
      logic [BLK_W-1:0] mask;
      mask = '1;
      if (nbytes != 3'd0) begin
         mask = ~({BLK_W{1'b1}} >> {nbytes, 3'b000});
      end
      return mask;
   endfunction

endpackage

// File: rtl/gctr_lat_cnt.sv
// gctr_lat_cnt -- cipher load-to-valid latency counter.
//
// Counts from the cycle load_i is high up to LAT; done_o rises exactly LAT
// cycles after the load cycle (the cycle the cipher output is valid) and stays
// high until the next load or clear.
//
// Ports:
//   clk      clock
//   reset    synchronous, active-high reset
//   load_i   cipher load issued this cycle; restarts the count
//   clear_i  abandon the count (done_o stays low until the next load)
//   done_o   latency elapsed
module gctr_lat_cnt
   import gctr_pkg::*;
#(
   parameter int unsigned LAT = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic clear_i,
   output logic done_o
);

   localparam logic [LAT_CNT_W-1:0] LAT_C = LAT_CNT_W'(LAT);
   localparam logic [LAT_CNT_W-1:0] ONE_C = LAT_CNT_W'(1);

   logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

   // Zero means idle; the count saturates at LAT.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = ONE_C;
      end else if (cnt_q != '0 && cnt_q != LAT_C) begin
         cnt_d = cnt_q + ONE_C;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == LAT_C);

endmodule

// File: rtl/gctr_ctrl_64.sv
// gctr_ctrl_64 -- GCTR sequencing controller around one shared PRESENT-80 core.
//
// Walks each message block through LOAD (pulse the core) -> WAIT (fixed core
// latency) -> XFER (take one input block) -> OUT (hold the XORed block until
// taken), advancing the counter block with inc32 between blocks.
//
// Build option: define GCTR_PREFETCH_EN to request the next keystream on
// entry to XFER so it overlaps the current block; without it the flow is
// strictly serial.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start, start_use_dflt        begin a message (IDLE only); pick ICB_DEFAULT
//   icb_init, key                initial counter block and key, latched at start
//   in_valid/in_ready/in_data/in_last/in_bytes       input block stream
//   out_valid/out_ready/out_data/out_last/out_bytes  output block stream
//   ks_load, ks_in, ks_key, ks_out                   cipher core interface
//   busy, done                   not IDLE; one-cycle pulse on final hand-off
module gctr_ctrl_64
   import gctr_pkg::*;
#(
   parameter int unsigned      CIPHER_LAT  = 32,
   parameter logic [BLK_W-1:0] ICB_DEFAULT = ICB_DFLT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             start_use_dflt,
   input  logic [BLK_W-1:0] icb_init,
   input  logic [KEY_W-1:0] key,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   input  logic             in_last,
   input  logic [2:0]       in_bytes,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             out_last,
   output logic [2:0]       out_bytes,
   output logic             ks_load,
   output logic [BLK_W-1:0] ks_in,
   output logic [KEY_W-1:0] ks_key,
   input  logic [BLK_W-1:0] ks_out,
   output logic             busy,
   output logic             done
);

   gctr_state_t      state_q, state_d;
   gctr_state_t      out_cont;      // where OUT goes after a non-final block
   logic [BLK_W-1:0] ctr_q;
   logic [KEY_W-1:0] key_q;
   logic [BLK_W-1:0] ks_q;
   logic [BLK_W-1:0] out_data_q;
   logic             out_last_q;
   logic [2:0]       out_bytes_q;
   logic             lat_done;
   logic             wait_ok;       // keystream being waited on is valid now

   gctr_lat_cnt #(.LAT(CIPHER_LAT)) u_lat_main (
      .clk     (clk),
      .reset   (reset),
      .load_i  (state_q == LOAD),
      .clear_i (1'b0),
      .done_o  (lat_done)
   );

`ifdef GCTR_PREFETCH_EN
   logic             pf_load;
   logic             pf_done;
   logic             pf_got_q;      // prefetch result already parked in pf_ks_q
   logic             wait_pf_q;     // WAIT was entered from OUT: wait on prefetch
   logic             xfer_new_q;    // first cycle of an XFER visit
   logic [BLK_W-1:0] pf_ks_q;

   assign pf_load = (state_q == XFER) && xfer_new_q;

   // Cleared in LOAD so a prefetch left over from an earlier message can
   // never be mistaken for a fresh one.
   gctr_lat_cnt #(.LAT(CIPHER_LAT)) u_lat_pf (
      .clk     (clk),
      .reset   (reset),
      .load_i  (pf_load),
      .clear_i (state_q == LOAD),
      .done_o  (pf_done)
   );

   assign wait_ok  = wait_pf_q ? pf_done : lat_done;
   assign out_cont = pf_done ? XFER : WAIT;

   always_ff @(posedge clk) begin
      if (reset) begin
         pf_got_q   <= 1'b0;
         wait_pf_q  <= 1'b0;
         xfer_new_q <= 1'b0;
         pf_ks_q    <= '0;
      end else begin
         xfer_new_q <= (state_d == XFER) && (state_q != XFER);
         if (state_q == LOAD) begin
            wait_pf_q <= 1'b0;
         end else if (state_q == OUT && out_ready && !out_last_q) begin
            wait_pf_q <= 1'b1;
         end
         // ks_out is only valid on the first done cycle, so park it then.
         if (pf_load || state_q == LOAD) begin
            pf_got_q <= 1'b0;
         end else if (pf_done && !pf_got_q) begin
            pf_got_q <= 1'b1;
            pf_ks_q  <= ks_out;
         end
      end
   end
`else
   assign wait_ok  = lat_done;
   assign out_cont = LOAD;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: state_d = WAIT;
         WAIT: if (wait_ok) state_d = XFER;
         XFER: if (in_valid) state_d = OUT;
         OUT: begin
            if (out_ready) begin
               state_d = out_last_q ? IDLE : out_cont;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      ks_load   = 1'b0;
      ks_in     = '0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state_q)
         IDLE: busy = 1'b0;
         LOAD: begin
            ks_load = 1'b1;
            ks_in   = ctr_q;
         end
         XFER: begin
            in_ready = 1'b1;
`ifdef GCTR_PREFETCH_EN
            if (pf_load) begin
               ks_load = 1'b1;
               ks_in   = inc32(ctr_q);
            end
`endif
         end
         OUT: begin
            out_valid = 1'b1;
            done      = out_ready && out_last_q;
         end
         default: ;
      endcase
   end

   // Counter, key, keystream and output block registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ctr_q       <= '0;
         key_q       <= '0;
         ks_q        <= '0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_bytes_q <= '0;
      end else begin
         if (state_q == IDLE && start) begin
            ctr_q <= start_use_dflt ? ICB_DEFAULT : icb_init;
            key_q <= key;
         end
         if (state_q == WAIT && wait_ok) begin
            ks_q <= ks_out;
         end
`ifdef GCTR_PREFETCH_EN
         if (state_q == OUT && out_ready && !out_last_q && pf_done) begin
            ks_q <= pf_got_q ? pf_ks_q : ks_out;
         end
`endif
         if (state_q == XFER && in_valid) begin
            out_data_q  <= (in_data ^ ks_q) & (in_last ? byte_mask(in_bytes) : '1);
            out_last_q  <= in_last;
            out_bytes_q <= in_bytes;
         end
         if (state_q == OUT && out_ready && !out_last_q) begin
            ctr_q <= inc32(ctr_q);
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_bytes = out_bytes_q;
   assign ks_key    = key_q;

endmodule

// File: tb/tb_gctr_ctrl_64.sv
// tb_gctr_ctrl_64 -- directed self-checking bench for gctr_ctrl_64 (serial build).
// Cipher stand-in: ks_out = ks_in ^ key[63:0], valid exactly CIPHER_LAT cycles
// after the ks_load cycle, garbage otherwise.
module tb_gctr_ctrl_64;

   localparam int LAT = 32;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start_use_dflt = 1'b0;
   logic [63:0] icb_init = '0;
   logic [79:0] key = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic        in_last = 1'b0;
   logic [2:0]  in_bytes = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;
   logic        out_last;
   logic [2:0]  out_bytes;
   logic        ks_load;
   logic [63:0] ks_in;
   logic [79:0] ks_key;
   logic [63:0] ks_out;
   logic        busy;
   logic        done;

   gctr_ctrl_64 #(.CIPHER_LAT(LAT)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .start_use_dflt (start_use_dflt),
      .icb_init       (icb_init),
      .key            (key),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_last        (in_last),
      .in_bytes       (in_bytes),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .out_bytes      (out_bytes),
      .ks_load        (ks_load),
      .ks_in          (ks_in),
      .ks_key         (ks_key),
      .ks_out         (ks_out),
      .busy           (busy),
      .done           (done)
   );

   // Cipher core stand-in
   logic [63:0]    pipe_d [LAT];
   logic [LAT-1:0] pipe_v;
   always @(posedge clk) begin
      if (reset) begin
         pipe_v <= '0;
      end else begin
         pipe_v <= {pipe_v[LAT-2:0], ks_load};
      end
      pipe_d[0] <= ks_in ^ ks_key[63:0];
      for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
   end
   assign ks_out = pipe_v[LAT-1] ? pipe_d[LAT-1] : 64'hDEAD_BEEF_0BAD_F00D;

   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   logic [63:0] ks_log [$];

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic sample();
      if (ks_load) ks_log.push_back(ks_in);
      if (done) done_cnt++;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"},  80'(in_ready),  80'(1'b0));
      check({tag, "_out_valid"}, 80'(out_valid), 80'(1'b0));
      check({tag, "_out_data"},  80'(out_data),  80'(64'h0));
      check({tag, "_out_last"},  80'(out_last),  80'(1'b0));
      check({tag, "_out_bytes"}, 80'(out_bytes), 80'(3'd0));
      check({tag, "_ks_load"},   80'(ks_load),   80'(1'b0));
      check({tag, "_ks_in"},     80'(ks_in),     80'(64'h0));
      check({tag, "_ks_key"},    ks_key,         80'h0);
      check({tag, "_busy"},      80'(busy),      80'(1'b0));
      check({tag, "_done"},      80'(done),      80'(1'b0));
   endtask

   // Leaves the bench at the negedge of the LOAD cycle.
   task automatic start_msg(input logic dflt, input logic [63:0] icb, input logic [79:0] k);
      start_use_dflt = dflt;
      icb_init       = icb;
      key            = k;
      start          = 1'b1;
      tick();
      start          = 1'b0;
   endtask

   // Waits for in_ready, hands over one block, checks the registered result.
   // Returns at the negedge of the OUT cycle; wait_n = cycles spent waiting.
   task automatic xfer_block(input string tag, input logic [63:0] data, input logic last,
                             input logic [2:0] bytes, input logic [63:0] exp, output int wait_n);
      int n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      wait_n = n;
      check({tag, "_in_ready"}, 80'(in_ready), 80'(1'b1));
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      in_bytes = bytes;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      in_bytes = '0;
      check({tag, "_out_valid"}, 80'(out_valid), 80'(1'b1));
      check({tag, "_out_data"},  80'(out_data),  80'(exp));
      check({tag, "_out_last"},  80'(out_last),  80'(last));
      check({tag, "_out_bytes"}, 80'(out_bytes), 80'(bytes));
      if (out_ready) check({tag, "_done"}, 80'(done), 80'(last));
      $display("blk %s in=%h out=%h last=%0d bytes=%0d wait=%0d",
               tag, data, out_data, out_last, out_bytes, n);
   endtask

   task automatic single_default(input string tag);
      int w;
      int dc0;
      ks_log.delete();
      dc0 = done_cnt;
      start_msg(1'b1, 64'h5555_5555_5555_5555, 80'h0);
      check({tag, "_ks_load"}, 80'(ks_load), 80'(1'b1));
      check({tag, "_ks_in"},   80'(ks_in),   80'(64'hABAC8CA6000AA98A));
      check({tag, "_busy"},    80'(busy),    80'(1'b1));
      xfer_block(tag, 64'h0, 1'b1, 3'd0, 64'hABAC8CA6000AA98A, w);
      check({tag, "_latency"}, 80'(w), 80'(LAT + 1));
      tick();
      check({tag, "_done_cnt"}, 80'(done_cnt - dc0), 80'(1));
      check({tag, "_nload"},    80'(ks_log.size()), 80'(1));
      check({tag, "_idle"},     80'(busy), 80'(1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int dc0;
      logic [79:0] k3;

      repeat (3) tick();
      check_idle("rst");
      reset = 1'b0;
      tick();

      // Single block with the default ICB
      single_default("sb");

      // Three blocks, explicit ICB, non-zero key
      k3 = 80'hFFFF_0F0F0F0F0F0F0F0F;
      ks_log.delete();
      dc0 = done_cnt;
      start_msg(1'b0, 64'h0000000100000002, k3);
      check("m3_ks_key", ks_key, k3);
      xfer_block("m3b0", 64'h0, 1'b0, 3'd0, 64'h0F0F0F0E0F0F0F0D, w);
      xfer_block("m3b1", 64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd3, 64'hF0F0F0F1F0F0F0F3, w);
      xfer_block("m3b2", 64'h123456789ABCDEF0, 1'b1, 3'd0, 64'h1D3B597695B3D1FB, w);
      tick();
      check("m3_done_cnt", 80'(done_cnt - dc0), 80'(1));
      check("m3_nload", 80'(ks_log.size()), 80'(3));
      check("m3_ks_in0", 80'(ks_log[0]), 80'(64'h0000000100000002));
      check("m3_ks_in1", 80'(ks_log[1]), 80'(64'h0000000100000003));
      check("m3_ks_in2", 80'(ks_log[2]), 80'(64'h0000000100000004));

      // Low-word wrap
      ks_log.delete();
      start_msg(1'b0, 64'h12345678FFFFFFFF, 80'h0);
      xfer_block("wr0", 64'h0, 1'b0, 3'd0, 64'h12345678FFFFFFFF, w);
      xfer_block("wr1", 64'h0, 1'b1, 3'd0, 64'h1234567800000000, w);
      tick();
      check("wr_ks_in1", 80'(ks_log[1]), 80'(64'h1234567800000000));

      // Partial final block
      start_msg(1'b0, 64'h0, 80'h0);
      xfer_block("part", 64'hFFFFFFFFFFFFFFFF, 1'b1, 3'd3, 64'hFFFFFF0000000000, w);
      tick();

      // Backpressure, with a start pulsed while busy
      ks_log.delete();
      dc0 = done_cnt;
      out_ready = 1'b0;
      start_msg(1'b0, 64'h1, 80'h0);
      xfer_block("bp", 64'hF0, 1'b1, 3'd0, 64'hF1, w);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            start          = 1'b1;
            start_use_dflt = 1'b1;
         end
         tick();
         start = 1'b0;
         check("bp_out_valid", 80'(out_valid), 80'(1'b1));
         check("bp_out_data",  80'(out_data),  80'(64'hF1));
         check("bp_in_ready",  80'(in_ready),  80'(1'b0));
         check("bp_done_held", 80'(done),      80'(1'b0));
      end
      out_ready = 1'b1;
      #1;
      check("bp_done", 80'(done), 80'(1'b1));
      sample();
      tick();
      check("bp_idle",     80'(busy), 80'(1'b0));
      check("bp_done_cnt", 80'(done_cnt - dc0), 80'(1));
      check("bp_nload",    80'(ks_log.size()), 80'(1));

      // Reset in the middle of WAIT, then a clean restart
      start_msg(1'b0, 64'h77, 80'h1234_5678_9ABC_DEF0_1111);
      repeat (5) tick();
      check("rw_busy", 80'(busy), 80'(1'b1));
      reset = 1'b1;
      tick();
      check_idle("rw");
      reset = 1'b0;
      tick();
      single_default("sb2");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gctr_ctrl_64.md
Name: gctr_ctrl_64

Overview:
Sequencing controller for the 64-bit GCTR (counter-mode) datapath built on the PRESENT-80 block cipher core.
- Accepts a message as a stream of 64-bit blocks on a valid/ready handshake.
- Generates the counter blocks, pulses the cipher core's load and waits its fixed latency.
- XORs the keystream with each data block and emits the result with backpressure.
- Sits between the GCM top-level framing logic and one shared PRESENT-80 instance.

Parameters:
CIPHER_LAT, 32, cycles from the ks_load cycle to the cycle ks_out is valid (sampled exactly then); legal range 1..63
ICB_DEFAULT, 64'hABAC8CA6000AA98A, counter block used when start_use_dflt=1

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  begin a message (accepted only in IDLE)
start_use_dflt  in  1  at start: 1 = use ICB_DEFAULT, 0 = use icb_init
icb_init  in  64  initial counter block
key  in  80  cipher key, latched at accepted start
in_valid  in  1  input block valid
in_ready  out  1  input block accepted when in_valid & in_ready
in_data  in  64  plaintext/ciphertext block
in_last  in  1  final block of message
in_bytes  in  3  valid bytes in final block, MSB-first; 0 = 8
out_valid  out  1  output block valid
out_ready  in  1  downstream accepts
out_data  out  64  in_data XOR keystream, masked
out_last  out  1  copy of in_last
out_bytes  out  3  copy of in_bytes
ks_load  out  1  one-cycle load pulse to cipher core
ks_in  out  64  counter block to cipher core
ks_key  out  80  latched key to cipher core
ks_out  in  64  cipher core output
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after last block is handed off

Behaviour:
- Reset value of every output is 0. FSM returns to IDLE, counters clear, and any in-flight block is discarded, including mid-WAIT or mid-OUT.
- States:
  - IDLE: start latches key and ICB → LOAD. A start outside IDLE is ignored.
  - LOAD: ks_load=1 for one cycle, ks_in=ctr → WAIT. The latency counter is cleared.
  - WAIT: count to CIPHER_LAT, then capture ks_out into ks_reg → XFER.
  - XFER: in_ready=1; on in_valid, compute the output block → OUT.
  - OUT: out_valid=1 until out_ready. If in_last → IDLE with done=1 that cycle; else ctr=inc32(ctr) → LOAD.
- Output stability: out_data, out_last and out_bytes are registered and hold stable while out_valid & !out_ready.
- Single-block latency: start → first out_valid = 1 + CIPHER_LAT + 1 + (in_valid wait) + 1 cycles.
- inc32: low 32 bits increment modulo 2^32 (0xFFFFFFFF → 0x00000000, no carry); upper 32 bits unchanged.
- Partial block (in_last=1, in_bytes=n≠0): bytes [63:64-8n] are valid. The remaining low bytes of out_data are forced to 0.
- in_bytes is ignored when in_last=0; that block is treated as a full 8 bytes.
- ks_key and the ICB are constant between start and done.
- in_ready is 0 outside XFER.
- Every message has ≥1 block; no zero-length message.

Optional Feature:
GCTR_PREFETCH_EN
- Defined: the next counter block is prefetched so its keystream overlaps the current block.
  - On entering XFER, the controller issues ks_load with inc32(ctr) and runs the latency count in parallel.
  - If the in_last block is taken, the prefetch result is discarded and the counter is not advanced.
  - OUT goes directly to XFER once the prefetch count has completed; otherwise it goes to WAIT.
  - Steady-state throughput is one block per max(CIPHER_LAT+1, handshake) cycles.
- Undefined: strictly serial flow as described in Behaviour.

Decomposition:
- Package gctr_pkg holds:
  - state enum (IDLE, LOAD, WAIT, XFER, OUT)
  - ICB default constant
  - width constants (BLK_W=64, KEY_W=80)
  - inc32 function
  - byte-mask function (in_bytes → 64-bit mask)
- One sub-module is natural: gctr_lat_cnt, the load-to-valid latency counter with a done flag. It is instantiated twice when GCTR_PREFETCH_EN is defined.
- The cipher core stays outside this block.

Test Plan:
Bench cipher model: ks_out = ks_in ^ key[63:0], valid CIPHER_LAT cycles after ks_load.
- Single block: start_use_dflt=1, key=0, in_data=0, in_last=1, in_bytes=0 → ks_in=ABAC8CA6000AA98A; out_data=ABAC8CA6000AA98A; done pulses once.
- Three blocks: icb_init=0000000100000002 → ks_in sequence …0002, …0003, …0004; three out_valid; done only after the third.
- Wrap: icb_init=12345678FFFFFFFF, two blocks → second ks_in=1234567800000000.
- Partial: in_bytes=3, in_data=FFFFFFFFFFFFFFFF, key=0, ICB=0 → out_data=FFFFFF0000000000, out_bytes=3.
- Backpressure: out_ready low 10 cycles → out_data stable and in_ready=0 throughout. Start pulsed while busy → ignored.
- Reset mid-WAIT → next cycle all outputs 0 and busy=0. A fresh start then reproduces the single-block result exactly.
